regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 tb/tb_regfile_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// 32x32 integer register file with write-to-read bypass and a per-register busy scoreboard.
// Optional debug read port enabled by defining REGFILE_DEBUG_PORT_EN.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  output logic            rvalid_o,
  output logic            stall_o,
  input  logic            issue_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            wen_i,
  input  logic [AW-1:0]   waddr_i,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
`else
  input  logic [XLEN-1:0] wdata_i
`endif
);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [NREGS-1:0] clr_mask_s;
  logic [NREGS-1:0] set_mask_s;
  logic             wr_s;
  logic             byp1_s;
  logic             byp2_s;
  logic             haz1_s;
  logic             haz2_s;
  logic             accept_s;
  logic             issue_ok_s;
  logic [XLEN-1:0]  rd1_s;
  logic [XLEN-1:0]  rd2_s;

  assign wr_s   = wen_i & (waddr_i != {AW{1'b0}});
  // Bypass only from a real write; x0 is never written so waddr!=0 implies raddr!=0.
  assign byp1_s = wr_s & (waddr_i == raddr1_i);
  assign byp2_s = wr_s & (waddr_i == raddr2_i);

  // A same-cycle write-back to the source clears that source's hazard.
  assign haz1_s   = rd_en_i & busy_r[raddr1_i] & ~(wen_i & (waddr_i == raddr1_i));
  assign haz2_s   = rd_en_i & busy_r[raddr2_i] & ~(wen_i & (waddr_i == raddr2_i));
  assign stall_o  = haz1_s | haz2_s;
  assign accept_s = rd_en_i & ~stall_o;

  assign rd1_s = byp1_s ? wdata_i : regs_r[raddr1_i];
  assign rd2_s = byp2_s ? wdata_i : regs_r[raddr2_i];

  assign issue_ok_s = issue_i & ~stall_o & (issue_rd_i != {AW{1'b0}});
  assign clr_mask_s = wr_s       ? ({{(NREGS-1){1'b0}}, 1'b1} << waddr_i)    : {NREGS{1'b0}};
  assign set_mask_s = issue_ok_s ? ({{(NREGS-1){1'b0}}, 1'b1} << issue_rd_i) : {NREGS{1'b0}};

  // Next scoreboard: write-back clears, accepted issue sets (set wins), bit 0 forced clear.
  always_comb begin
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~{{(NREGS-1){1'b0}}, 1'b1};
  end

  // Register array and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      busy_r <= {NREGS{1'b0}};
    end else begin
      if (wr_s) begin
        regs_r[waddr_i] <= wdata_i;
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Registered operand outputs; they hold when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1_o <= {XLEN{1'b0}};
      rdata2_o <= {XLEN{1'b0}};
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= accept_s;
      if (accept_s) begin
        rdata1_o <= rd1_s;
        rdata2_o <= rd2_s;
      end
    end
  end

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data_o = regs_r[dbg_addr_i];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: per-cycle comparison against a rule-level model
// plus hand-computed literal expectations.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic        rd_en_i;
  logic [4:0]  raddr1_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata1_o;
  logic [31:0] rdata2_o;
  logic        rvalid_o;
  logic        stall_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic        wen_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_data_o;
`endif

  regfile_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (rd_en_i),
    .raddr1_i   (raddr1_i),
    .raddr2_i   (raddr2_i),
    .rdata1_o   (rdata1_o),
    .rdata2_o   (rdata2_o),
    .rvalid_o   (rvalid_o),
    .stall_o    (stall_o),
    .issue_i    (issue_i),
    .issue_rd_i (issue_rd_i),
    .wen_i      (wen_i),
    .waddr_i    (waddr_i),
`ifdef REGFILE_DEBUG_PORT_EN
    .wdata_i    (wdata_i),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
`else
    .wdata_i    (wdata_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Model state: architectural values, pending destinations, expected outputs.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] e_r1;
  logic [31:0] e_r2;
  logic        e_rv;
  bit          known;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard(input logic [4:0] a);
    return rd_en_i && m_busy[a] && !(wen_i && waddr_i == a);
  endfunction

  function automatic logic [31:0] m_value(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wen_i && waddr_i == a) return wdata_i;
    return m_regs[a];
  endfunction

  // Drive one cycle's inputs at the falling edge, compare, then advance the model
  // to what the next rising edge must produce.
  task automatic cyc(input logic r, input logic rde, input logic [4:0] a1, input logic [4:0] a2,
                     input logic iss, input logic [4:0] ird,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bit st;
    @(negedge clk);
    rst = r; rd_en_i = rde; raddr1_i = a1; raddr2_i = a2;
    issue_i = iss; issue_rd_i = ird; wen_i = we; waddr_i = wa; wdata_i = wd;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr_i = 5'd5;
`endif
    #2;
    st = m_hazard(a1) || m_hazard(a2);
    if (known) begin
      chk("rdata1", rdata1_o, e_r1);
      chk("rdata2", rdata2_o, e_r2);
      chk("rvalid", {31'd0, rvalid_o}, {31'd0, e_rv});
      chk("stall", {31'd0, stall_o}, {31'd0, st});
`ifdef REGFILE_DEBUG_PORT_EN
      chk("dbg_x5", dbg_data_o, m_regs[5]);
`endif
    end
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
      e_r1 = 32'h0; e_r2 = 32'h0; e_rv = 1'b0;
      known = 1'b1;
    end else begin
      e_rv = rde && !st;
      if (e_rv) begin
        e_r1 = m_value(a1);
        e_r2 = m_value(a2);
      end
      if (we && wa != 5'd0) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (iss && !st && ird != 5'd0) m_busy[ird] = 1'b1;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    checks = 0; errors = 0; known = 1'b0;
    e_r1 = 32'h0; e_r2 = 32'h0; e_rv = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    rst = 1'b1; rd_en_i = 1'b0; raddr1_i = 5'd0; raddr2_i = 5'd0;
    issue_i = 1'b0; issue_rd_i = 5'd0; wen_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr_i = 5'd5;
`endif

    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    cyc(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd8, 1'b1, 5'd8, 32'h1111_1111);
    // Reset state, read x0/x5.
    cyc(1'b0, 1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_reset_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("lit_read0_stall", {31'd0, stall_o}, 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h0000_1234);
    chk("lit_read0_r1", rdata1_o, 32'h0);
    chk("lit_read0_r2", rdata2_o, 32'h0);
    chk("lit_read0_rvalid", {31'd0, rvalid_o}, 32'd1);
    cyc(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_idle_rvalid", {31'd0, rvalid_o}, 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("lit_x5", rdata1_o, 32'h0000_1234);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    // Bypass on source 2 while source 1 reads x5.
    cyc(1'b0, 1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    chk("lit_x0_r1", rdata1_o, 32'h0);
    chk("lit_x0_r2", rdata2_o, 32'h0);
    idle();
    chk("lit_bypass_r2", rdata2_o, 32'hDEAD_BEEF);
    chk("lit_bypass_r1", rdata1_o, 32'h0000_1234);
    // Issue x3, stalled read, then resolve with same-cycle write-back.
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
    cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_stall_x3", {31'd0, stall_o}, 32'd1);
    cyc(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h0000_0055);
    chk("lit_stall_hold_r1", rdata1_o, 32'h0000_1234);
    chk("lit_stall_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("lit_wb_resolves", {31'd0, stall_o}, 32'd0);
    idle();
    chk("lit_x3_r1", rdata1_o, 32'h0000_0055);
    cyc(1'b0, 1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_x3_free", {31'd0, stall_o}, 32'd0);
    // Issue and write-back of x9 in the same cycle: set wins.
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h0000_0010);
    cyc(1'b0, 1'b1, 5'd9, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0);
    chk("lit_x9_busy", {31'd0, stall_o}, 32'd1);
    cyc(1'b0, 1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_x4_not_busy", {31'd0, stall_o}, 32'd0);
    cyc(1'b0, 1'b1, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_x9_still_busy", {31'd0, stall_o}, 32'd1);
    cyc(1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0020);
    idle();
    chk("lit_x9_r1", rdata1_o, 32'h0000_0020);
    chk("lit_x9_r2", rdata2_o, 32'h0000_0020);
    // Source equals destination: old value, no self-stall.
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h0000_0066);
    cyc(1'b0, 1'b1, 5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 5'd0, 32'h0);
    chk("lit_self_nostall", {31'd0, stall_o}, 32'd0);
    cyc(1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_self_old", rdata1_o, 32'h0000_0066);
    chk("lit_x6_busy", {31'd0, stall_o}, 32'd1);
    // Reset in the middle of a stall.
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'h0);
    cyc(1'b0, 1'b1, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_x12_busy", {31'd0, stall_o}, 32'd1);
    cyc(1'b1, 1'b1, 5'd12, 5'd0, 1'b1, 5'd13, 1'b1, 5'd14, 32'h0000_0077);
    cyc(1'b0, 1'b1, 5'd12, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("lit_rst_r1", rdata1_o, 32'h0);
    chk("lit_rst_r2", rdata2_o, 32'h0);
    chk("lit_rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    cyc(1'b0, 1'b1, 5'd14, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("lit_rst_x5", rdata2_o, 32'h0);
    chk("lit_rst_x6_free", {31'd0, stall_o}, 32'd0);
    // Short directed tail of mixed traffic, checked by the model.
    for (int k = 1; k < 16; k++) begin
      cyc(1'b0, 1'b1, 5'(k), 5'(31 - k), (k % 3) == 0, 5'(k + 1),
          (k % 2) == 0, 5'(k), 32'hA5A5_0000 + 32'(k));
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, 5'(k * 3), 5'(k * 3), 1'b0, 5'd0, 1'b1, 5'(k * 3 + 1), 32'h0F0F_0000 + 32'(k));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
